// File: rtl/vec_sum_acc_fp.sv
// Reduces one vector of signed fixed-point products per beat with a pipelined
// adder tree, then accumulates beat sums over an i_last-delimited group.
module vec_sum_acc_fp #(
  parameter int exp_width = 5,
  parameter int man_width = 2,
  parameter int length    = 32,
  parameter int max_beats = 64,
  parameter int prd_width = 2 * ((1 << exp_width) + man_width),
  parameter int levels    = $clog2(length),
  parameter int sum_width = prd_width + levels,
  parameter int acc_width = sum_width + $clog2(max_beats),
  parameter int cnt_width = $clog2(max_beats + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [prd_width-1:0] i_prd [length],
  input  logic                        i_last,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [acc_width-1:0] o_sum,
  output logic        [cnt_width-1:0] o_count,
  output logic                        o_err
);

  localparam int npad = 1 << levels;
  localparam logic [cnt_width-1:0] cnt_max = cnt_width'(max_beats);

  logic                        adv_s;
  logic signed [sum_width-1:0] leaf_d [npad];
  logic signed [sum_width-1:0] leaf_q [npad];
  logic signed [sum_width-1:0] node_d [1:npad-1];
  logic signed [sum_width-1:0] node_q [1:npad-1];
  logic [levels:0]             vld_q;
  logic [levels:0]             last_q;

  logic                        first_q;
  logic signed [acc_width-1:0] acc_q, acc_d, tree_ext_s;
  logic [cnt_width-1:0]        cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic                        ovalid_q;
  logic signed [acc_width-1:0] osum_q;
  logic [cnt_width-1:0]        ocount_q;
  logic                        oerr_q;

  assign adv_s   = !ovalid_q || i_ready;
  assign o_ready = adv_s;
  assign o_valid = ovalid_q;
  assign o_sum   = osum_q;
  assign o_count = ocount_q;
  assign o_err   = oerr_q;

  // Leaves are sign-extended to the full tree width; padding leaves read zero.
  for (genvar gi = 0; gi < npad; gi++) begin : g_leaf
    if (gi < length) begin : g_real
      assign leaf_d[gi] = sum_width'(i_prd[gi]);
    end else begin : g_pad
      assign leaf_d[gi] = {sum_width{1'b0}};
    end
  end

  // Heap-ordered tree: node k sums children 2k and 2k+1, the deepest level reads the leaves.
  for (genvar gk = 1; gk < npad; gk++) begin : g_node
    if (2 * gk >= npad) begin : g_bottom
      assign node_d[gk] = leaf_q[2*gk-npad] + leaf_q[2*gk+1-npad];
    end else begin : g_inner
      assign node_d[gk] = node_q[2*gk] + node_q[2*gk+1];
    end
  end

  // Tree data registers; qualified by the valid pipeline, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (adv_s) begin
      leaf_q <= leaf_d;
      node_q <= node_d;
    end
  end

  // Valid/last pipeline alongside the tree; index levels lines up with the root.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q  <= {(levels+1){1'b0}};
      last_q <= {(levels+1){1'b0}};
    end else if (adv_s) begin
      vld_q  <= {vld_q[levels-1:0], i_valid};
      last_q <= {last_q[levels-1:0], i_valid & i_last};
    end
  end

  // Next accumulator state; the first beat of a group restarts from zero.
  always_comb begin
    tree_ext_s = acc_width'(node_q[1]);
    acc_d      = (first_q ? {acc_width{1'b0}} : acc_q) + tree_ext_s;
    cnt_d      = first_q ? cnt_width'(1) :
                 ((cnt_q == cnt_max) ? cnt_q : cnt_q + cnt_width'(1));
    err_d      = !first_q && (err_q || (cnt_q == cnt_max));
  end

  // Group accumulator and registered result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      first_q  <= 1'b1;
      acc_q    <= {acc_width{1'b0}};
      cnt_q    <= {cnt_width{1'b0}};
      err_q    <= 1'b0;
      ovalid_q <= 1'b0;
      osum_q   <= {acc_width{1'b0}};
      ocount_q <= {cnt_width{1'b0}};
      oerr_q   <= 1'b0;
    end else if (adv_s) begin
      if (vld_q[levels]) begin
        if (last_q[levels]) begin
          osum_q   <= acc_d;
          ocount_q <= cnt_d;
          oerr_q   <= err_d;
          ovalid_q <= 1'b1;
          first_q  <= 1'b1;
        end else begin
          acc_q    <= acc_d;
          cnt_q    <= cnt_d;
          err_q    <= err_d;
          ovalid_q <= 1'b0;
          first_q  <= 1'b0;
        end
      end else begin
        ovalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vec_sum_acc_fp.sv
// Directed-vector bench for vec_sum_acc_fp at default parameters.
module tb_vec_sum_acc_fp;

  localparam int LEN = 32;
  localparam int PW  = 68;
  localparam int AW  = 79;
  localparam int CW  = 7;

  logic                 i_clk = 1'b0;
  logic                 i_rst, i_valid, i_last, i_ready;
  logic                 o_ready, o_valid, o_err;
  logic signed [PW-1:0] prd [LEN];
  logic signed [AW-1:0] o_sum;
  logic [CW-1:0]        o_count;

  int n_total = 0;
  int n_bad   = 0;

  logic signed [AW-1:0] exp_sum_q [$];
  logic [CW-1:0]        exp_cnt_q [$];
  logic                 exp_err_q [$];

  vec_sum_acc_fp dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_prd  (prd),
    .i_last (i_last),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sum  (o_sum),
    .o_count(o_count),
    .o_err  (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grp(input logic signed [AW-1:0] s, input int c, input logic e);
    exp_sum_q.push_back(s);
    exp_cnt_q.push_back(CW'(c));
    exp_err_q.push_back(e);
  endtask

  task automatic send(input logic signed [PW-1:0] v0, input logic signed [PW-1:0] vr,
                      input logic last);
    int n = 0;
    bit ok = 1'b0;
    for (int i = 0; i < LEN; i++) prd[i] = (i == 0) ? v0 : vr;
    i_valid = 1'b1;
    i_last  = last;
    while (!ok && n < 100) begin
      @(negedge i_clk);
      if (o_ready) begin
        @(posedge i_clk);
        ok = 1'b1;
      end
      n++;
    end
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_sum_q.size() != 0 && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (exp_sum_q.size() != 0) check("drain_timeout", exp_sum_q.size(), 0);
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard: every completed output transfer must match the next expected group.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_sum_q.size() == 0) begin
        check("extra_out", 1, 0);
      end else begin
        check("sum",   o_sum,   exp_sum_q.pop_front());
        check("count", o_count, exp_cnt_q.pop_front());
        check("err",   o_err,   exp_err_q.pop_front());
      end
    end
  end

  initial begin
    int k;
    i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    for (int i = 0; i < LEN; i++) prd[i] = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    @(negedge i_clk);
    check("rst_valid", o_valid, 0);
    check("rst_sum",   o_sum,   0);
    check("rst_count", o_count, 0);
    check("rst_err",   o_err,   0);
    check("rst_ready", o_ready, 1);
    @(posedge i_clk); #1;

    // Single beat, latency measurement.
    expect_grp(32, 1, 1'b0);
    send(1, 1, 1'b1);
    k = 0;
    @(negedge i_clk);
    while (!o_valid && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    check("latency", k, 6);
    drain();

    // Three-beat group.
    expect_grp(68, 3, 1'b0);
    send(1, 1, 1'b0);
    send(-2, -2, 1'b0);
    send(100, 0, 1'b1);
    drain();

    // Streaming single-beat groups.
    for (int j = 0; j < 8; j++) expect_grp(32 * j, 1, 1'b0);
    fork
      begin
        for (int j = 0; j < 8; j++) send(j, j, 1'b1);
      end
      begin
        int n = 0;
        while (!o_valid && n < 50) begin
          @(negedge i_clk);
          n++;
        end
        if (!o_valid) check("stream_wait", 0, 1);
        for (int j = 0; j < 8; j++) begin
          check("stream_vld", o_valid, 1);
          if (j < 7) @(negedge i_clk);
        end
      end
    join
    drain();

    // Backpressure with more beats than the pipeline can hold.
    i_ready = 1'b0;
    for (int j = 0; j < 8; j++) expect_grp(32 * (10 + j), 1, 1'b0);
    fork
      begin
        for (int j = 0; j < 8; j++) send(10 + j, 10 + j, 1'b1);
      end
      begin
        int n = 0;
        while (!o_valid && n < 50) begin
          @(negedge i_clk);
          n++;
        end
        for (int j = 0; j < 10; j++) begin
          check("bp_valid", o_valid, 1);
          check("bp_ready", o_ready, 0);
          check("bp_hold",  o_sum,   320);
          @(negedge i_clk);
        end
        @(posedge i_clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a group discards it.
    send(3, 3, 1'b0);
    send(3, 3, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("mid_rst_ready", o_ready, 1);
    check("mid_rst_valid", o_valid, 0);
    @(posedge i_clk); #1;
    expect_grp(160, 1, 1'b0);
    send(5, 5, 1'b1);
    drain();

    // Extremes: 64 beats of max positive, then 64 beats of max negative.
    expect_grp({1'b0, {67{1'b1}}, 11'b0}, 64, 1'b0);
    for (int j = 0; j < 64; j++)
      send({1'b0, {67{1'b1}}}, {1'b0, {67{1'b1}}}, (j == 63));
    expect_grp({1'b1, 78'b0}, 64, 1'b0);
    for (int j = 0; j < 64; j++)
      send({1'b1, 67'b0}, {1'b1, 67'b0}, (j == 63));
    drain();

    // 65-beat group overflows the guaranteed range.
    expect_grp(2080, 64, 1'b1);
    for (int j = 0; j < 65; j++) send(1, 1, (j == 64));
    drain();

    check("leftover", exp_sum_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_sum_acc_fp.md
Name: vec_sum_acc_fp

Overview:
Downstream consumer of the elementwise FP product stage (vec_mul_fp). It takes one vector of `length` signed fixed-point products per accepted beat and reduces it with a pipelined adder tree. It then accumulates the per-beat sums across a group of beats, delimited by `i_last`, to form one dot-product partial sum per group. It has valid/ready handshakes on both sides and a single global stall.

Parameters:
- exp_width, 5: exponent width of the FP operands feeding the product stage.
- man_width, 2: mantissa width of the FP operands.
- length, 32: products per beat, ≥2. Non-power-of-2 values are zero-padded up to 2^levels.
- max_beats, 64: maximum beats per group that are guaranteed free of overflow.
- prd_width, 2*((1<<exp_width)+man_width): width of each signed product (68 at defaults).
- levels, $clog2(length): adder-tree depth (5 at defaults).
- sum_width, prd_width+levels: width of the tree output.
- acc_width, sum_width+$clog2(max_beats): width of the accumulator and of `o_sum`.
- cnt_width, $clog2(max_beats+1): width of the beat counter.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous reset, active-high.
- i_valid, in, 1: input beat valid.
- o_ready, out, 1: block can accept a beat.
- i_prd, in, signed [prd_width-1:0] [length]: product vector.
- i_last, in, 1: this beat closes the current group.
- o_valid, out, 1: group result valid.
- i_ready, in, 1: downstream accepts the result.
- o_sum, out, signed [acc_width-1:0]: accumulated group sum.
- o_count, out, [cnt_width-1:0]: number of beats in the group, saturating at max_beats.
- o_err, out, 1: the group contained more than max_beats beats.

Behaviour:
- Advance condition: `adv = !o_valid || i_ready`. All pipeline registers update only when `adv` is high.
- Handshake outputs:
  - `o_ready = adv`, combinational.
  - A beat is accepted on a rising edge where `i_valid && o_ready`.
- Tree:
  - `levels` register stages; each stage adds adjacent pairs.
  - All operands are sign-extended to `sum_width` before addition, so the tree is exact with no overflow.
  - Each stage carries a valid bit and a last bit.
  - On an `adv` edge, a stage captures its predecessor. A bubble (invalid input) propagates as valid = 0.
- Accumulate stage: on an `adv` edge with tree-output valid = 1:
  - `acc_next = (first ? 0 : acc) + sext(tree_sum)`.
  - `cnt_next = first ? 1 : min(cnt+1, max_beats)`.
  - `err_next = (first ? 0 : err) | (!first && cnt == max_beats)`.
  - If last: set `o_sum = acc_next`, `o_count = cnt_next`, `o_err = err_next`, `o_valid = 1`, and `first = 1`.
  - If not last: `acc = acc_next`, `cnt = cnt_next`, `err = err_next`, `first = 0`, and `o_valid = 0`.
- On an `adv` edge with tree-output valid = 0: `o_valid = 0`.
- Output stability: while `o_valid && !i_ready`, `o_sum`, `o_count` and `o_err` hold and the whole pipeline freezes. No beat is dropped or duplicated.
- Latency: a beat accepted at edge T with `i_last = 1` and no stall gives `o_valid = 1` after edge T+levels+1 (6 cycles at defaults).
- Throughput: one beat per cycle when `i_ready` is held high. Consecutive single-beat groups produce results on consecutive cycles.
- Overflow: beyond max_beats the accumulator wraps two's-complement and `o_err` flags the group. Within max_beats the result is exact.
- Reset (synchronous, takes priority over everything, including mid-group or mid-stall):
  - All stage valids = 0, `first = 1`, `acc = 0`, `cnt = 0`, `err = 0`.
  - `o_valid = 0`, `o_sum = 0`, `o_count = 0`, `o_err = 0`.
  - `o_ready = 1` in the cycle after reset.
  - In-flight partial groups are discarded.
- `i_prd` and `i_last` are ignored when `i_valid = 0`.

Test Plan:
- Single beat, all 32 products = 1, `i_last = 1`, `i_ready = 1` → `o_valid` 6 cycles after acceptance, `o_sum = 32`, `o_count = 1`, `o_err = 0`.
- Three-beat group:
  - beat 1: all products = 1;
  - beat 2: all products = -2;
  - beat 3: `prd[0] = 100`, others 0, with `i_last = 1`.
  - → `o_sum = 68`, `o_count = 3`, single `o_valid` pulse.
- Backpressure: hold `i_ready = 0` for 10 cycles with `o_valid = 1` while driving new beats → `o_ready = 0`, outputs frozen. After releasing `i_ready`, all beats appear in order with correct sums.
- Streaming single-beat groups: 8 consecutive beats, beat k has all products = k, all with `i_last = 1` → 8 consecutive `o_valid` cycles with `o_sum = 32k` for k = 0..7.
- Reset mid-operation: 2 beats with no last, assert `i_rst` for 1 cycle, then a single beat with all products = 5 and `i_last = 1` → `o_sum = 160`, `o_count = 1`. The pre-reset beats contribute nothing.
- Extremes and overflow:
  - 64 beats with all products = 2^67−1, then 64 beats with all = −2^67 → both sums exact, `o_err = 0`.
  - A 65-beat group → `o_err = 1`, `o_count = 64`.
